// File: rtl/trdb_tb_grant_shaper_if.sv
// trdb_tb_grant_shaper_if: packet handshake and capture-FIFO bus of the trace sink
//
// Signals:
//   packet_word_valid_i  DUV word valid
//   packet_word_i        DUV word (DATA_WIDTH)
//   grant_o              registered grant back to the DUV
//   pop_i                checker consumes the FIFO head
//   data_o               FIFO head (DATA_WIDTH)
//   data_valid_o         FIFO non-empty
//   fifo_full_o          FIFO holds FIFO_DEPTH words
// Modports:
//   master  DUV/checker side (drives valid, word, pop)
//   slave   sink side (drives grant and FIFO outputs)
interface trdb_tb_grant_shaper_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  packet_word_valid_i;
    logic [DATA_WIDTH-1:0] packet_word_i;
    logic                  grant_o;
    logic                  pop_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  data_valid_o;
    logic                  fifo_full_o;

    modport master (
        output packet_word_valid_i, packet_word_i, pop_i,
        input  grant_o, data_o, data_valid_o, fifo_full_o
    );

    modport slave (
        input  packet_word_valid_i, packet_word_i, pop_i,
        output grant_o, data_o, data_valid_o, fifo_full_o
    );
endinterface

// File: rtl/trdb_tb_grant_shaper.sv
// trdb_tb_grant_shaper: testbench-side packet sink with selectable grant backpressure
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   mode_i         0 ALWAYS, 1 RANDOM, 2 DELAY, 3 STALL
//   rand_thresh_i  RANDOM mode: grant when lfsr[7:0] < threshold
//   delay_i        DELAY mode wait cycles
//   bus            trdb_tb_grant_shaper_if.slave (handshake + capture FIFO)
//   word_count_o   accepted-word counter (wraps)
//   proto_err_o    sticky handshake violation flag
// Optional: define TRDB_TB_SINK_LOG_EN to print each transfer and protocol
// error; functional behaviour is identical either way.
module trdb_tb_grant_shaper #(
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DELAY_W    = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode_i,
    input  logic [7:0]             rand_thresh_i,
    input  logic [DELAY_W-1:0]     delay_i,
    trdb_tb_grant_shaper_if.slave  bus,
    output logic [31:0]            word_count_o,
    output logic                   proto_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} state_t;

    state_t                state_q, state_d;
    logic [DELAY_W-1:0]    cnt_q, cnt_d;
    logic [15:0]           lfsr_q;
    logic                  lfsr_fb;
    logic                  grant_q, grant_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count_q, count_d;
    logic [31:0]           word_cnt_q;
    logic                  err_q, err_d;
    logic                  prev_stall_q;
    logic [DATA_WIDTH-1:0] prev_word_q;
    logic                  xfer, pop, room;

    assign xfer    = bus.packet_word_valid_i && grant_q;
    assign pop     = bus.pop_i && (count_q != '0);
    assign count_d = count_q + (AW+1)'(xfer) - (AW+1)'(pop);
    // Grant is decided on the occupancy after this edge, so a granted word
    // always has a free slot.
    assign room    = count_d < (AW+1)'(FIFO_DEPTH);
    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    // A stalled word (valid without grant) must be held unchanged next cycle.
    assign err_d   = err_q | (prev_stall_q &&
                     (!bus.packet_word_valid_i || bus.packet_word_i != prev_word_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = 1'b0;
        case (mode_i)
            2'd0: grant_d = room;
            2'd1: grant_d = room && (lfsr_q[7:0] < rand_thresh_i);
            2'd2: begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.packet_word_valid_i) begin
                            cnt_d   = delay_i;
                            state_d = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q == '0) begin
                            state_d = S_GRANT;
                            grant_d = room;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    S_GRANT: begin
                        if (xfer) state_d = S_IDLE;
                        else      grant_d = room;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            default: grant_d = 1'b0;
        endcase
        // The delay FSM only lives while DELAY mode is selected.
        if (mode_i != 2'd2) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            grant_q      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            word_cnt_q   <= '0;
            err_q        <= 1'b0;
            prev_stall_q <= 1'b0;
            prev_word_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= {lfsr_q[14:0], lfsr_fb};
            grant_q      <= grant_d;
            count_q      <= count_d;
            word_cnt_q   <= word_cnt_q + 32'(xfer);
            err_q        <= err_d;
            prev_stall_q <= bus.packet_word_valid_i && !grant_q;
            prev_word_q  <= bus.packet_word_i;
            if (xfer) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: grant is low during reset so nothing is written,
    // and data_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (xfer) mem[wr_ptr] <= bus.packet_word_i;
    end

    assign bus.grant_o      = grant_q;
    assign bus.data_valid_o = count_q != '0;
    assign bus.data_o       = bus.data_valid_o ? mem[rd_ptr] : '0;
    assign bus.fifo_full_o  = count_q == (AW+1)'(FIFO_DEPTH);
    assign word_count_o     = word_cnt_q;
    assign proto_err_o      = err_q;

`ifdef TRDB_TB_SINK_LOG_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (xfer)
                $display("[SINK]  @%0t: word %h (#%0d)", $time, bus.packet_word_i, word_cnt_q + 32'd1);
            if (err_d && !err_q)
                $display("[SINK]  @%0t: protocol error", $time);
        end
    end
`endif
endmodule

// File: tb/tb_trdb_tb_grant_shaper.sv
// tb_trdb_tb_grant_shaper: directed and randomized checks of the grant shaper against a queue-based model
module tb_trdb_tb_grant_shaper;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  thresh = 8'd0;
    logic [3:0]  dly = 4'd0;
    logic [31:0] wc;
    logic        perr;

    trdb_tb_grant_shaper_if #(.DATA_WIDTH(DW)) bus ();

    trdb_tb_grant_shaper #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DELAY_W(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .rand_thresh_i(thresh),
        .delay_i(dly), .bus(bus), .word_count_o(wc), .proto_err_o(perr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    bit            mg;
    logic [31:0]   mwc;
    bit            merr;
    logic [15:0]   ml;
    int            mst;
    int            mcnt;
    bit            pstall;
    logic [DW-1:0] pword;
    bit            last_xfer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mg = 0; mwc = 0; merr = 0; ml = 16'hACE1;
        mst = 0; mcnt = 0; pstall = 0; pword = '0; last_xfer = 0;
    endtask

    task automatic check_all();
        chk("grant", 32'(bus.grant_o), 32'(mg));
        chk("data_valid", 32'(bus.data_valid_o), 32'(mq.size() > 0));
        chk("data", bus.data_o, mq.size() > 0 ? mq[0] : 32'd0);
        chk("full", 32'(bus.fifo_full_o), 32'(mq.size() == DEPTH));
        chk("word_count", wc, mwc);
        chk("proto_err", 32'(perr), 32'(merr));
    endtask

    // One clock: advance the model with the inputs currently applied, then check.
    task automatic cyc();
        bit            v, xf, pp, room, ng;
        logic [DW-1:0] w;
        int            ns;
        v    = bus.packet_word_valid_i;
        w    = bus.packet_word_i;
        xf   = v && mg;
        pp   = bus.pop_i && mq.size() > 0;
        ns   = mq.size() + int'(xf) - int'(pp);
        room = ns < DEPTH;
        ng   = 0;
        if (mode == 2'd0) ng = room;
        else if (mode == 2'd1) ng = room && (ml[7:0] < thresh);
        else if (mode == 2'd2) begin
            if (mst == 0) begin
                if (v) begin mcnt = int'(dly); mst = 1; end
            end else if (mst == 1) begin
                if (mcnt == 0) begin mst = 2; ng = room; end
                else mcnt--;
            end else begin
                if (xf) mst = 0;
                else ng = room;
            end
        end
        if (mode != 2'd2) begin mst = 0; mcnt = 0; end
        if (pstall && (!v || w != pword)) merr = 1;
        pstall = v && !mg;
        pword  = w;
        if (pp) void'(mq.pop_front());
        if (xf) begin mq.push_back(w); mwc = mwc + 32'd1; end
        ml = {ml[14:0], ^(ml & 16'hB400)};
        mg = ng;
        last_xfer = xf;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.packet_word_valid_i = 1'b0;
        bus.packet_word_i = '0;
        bus.pop_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    bit [999:0] seq1, seq2;

    initial begin
        int k, g, mism;
        model_reset();
        bus.packet_word_valid_i = 1'b0;
        bus.packet_word_i = '0;
        bus.pop_i = 1'b0;

        // ALWAYS, streaming 1..20 with pop every cycle
        do_reset();
        bus.pop_i = 1'b1;
        bus.packet_word_valid_i = 1'b1;
        bus.packet_word_i = 32'd1;
        for (int i = 0; i < 60 && bus.packet_word_valid_i; i++) begin
            cyc();
            if (i == 0) chk("grant_cycle1", 32'(bus.grant_o), 32'd1);
            if (last_xfer) begin
                bus.packet_word_i = bus.packet_word_i + 32'd1;
                if (bus.packet_word_i > 32'd20) bus.packet_word_valid_i = 1'b0;
            end
        end
        repeat (3) cyc();
        chk("stream_count", wc, 32'd20);
        chk("stream_perr", 32'(perr), 32'd0);

        // ALWAYS, no pops: fill to full, then one pop admits exactly one more
        do_reset();
        bus.packet_word_valid_i = 1'b1;
        bus.packet_word_i = 32'd100;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (last_xfer) bus.packet_word_i = bus.packet_word_i + 32'd1;
        end
        chk("fill_count", wc, 32'd8);
        chk("fill_full", 32'(bus.fifo_full_o), 32'd1);
        chk("fill_grant", 32'(bus.grant_o), 32'd0);
        bus.pop_i = 1'b1;
        cyc();
        bus.pop_i = 1'b0;
        chk("regrant", 32'(bus.grant_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (last_xfer) bus.packet_word_i = bus.packet_word_i + 32'd1;
        end
        chk("refill_count", wc, 32'd9);

        // DELAY, delay_i=3: grant rises 5 cycles after valid is first seen
        mode = 2'd2;
        dly = 4'd3;
        do_reset();
        bus.pop_i = 1'b1;
        cyc();
        bus.packet_word_valid_i = 1'b1;
        bus.packet_word_i = 32'hDEAD_0001;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            cyc();
            if (bus.grant_o) k = i;
        end
        chk("delay_rise", 32'(k), 32'd5);
        for (int i = 0; i < 5 && bus.packet_word_valid_i; i++) begin
            cyc();
            if (last_xfer) bus.packet_word_valid_i = 1'b0;
        end
        repeat (3) cyc();
        chk("delay_count", wc, 32'd1);
        chk("delay_grant_low", 32'(bus.grant_o), 32'd0);

        // RANDOM, threshold 0 never grants
        mode = 2'd1;
        thresh = 8'd0;
        do_reset();
        bus.packet_word_valid_i = 1'b1;
        bus.packet_word_i = 32'h55;
        g = 0;
        for (int i = 0; i < 100; i++) begin cyc(); g += int'(bus.grant_o); end
        chk("thresh0_grants", 32'(g), 32'd0);

        // RANDOM, threshold 128: roughly half, repeatable from the seed
        thresh = 8'd128;
        do_reset();
        g = 0;
        for (int i = 0; i < 1000; i++) begin cyc(); seq1[i] = bus.grant_o; g += int'(bus.grant_o); end
        chk("rand_in_range", 32'(g >= 400 && g <= 600), 32'd1);
        do_reset();
        mism = 0;
        for (int i = 0; i < 1000; i++) begin cyc(); seq2[i] = bus.grant_o; end
        for (int i = 0; i < 1000; i++) mism += int'(seq1[i] != seq2[i]);
        chk("rand_repeat", 32'(mism), 32'd0);

        // Randomized mix of modes, pops and legal DUV traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                mode = 2'($urandom_range(0, 3));
                thresh = 8'($urandom);
                dly = 4'($urandom_range(0, 5));
            end
            bus.pop_i = 1'($urandom % 2);
            if (!bus.packet_word_valid_i || last_xfer) begin
                bus.packet_word_valid_i = ($urandom % 4) != 0;
                bus.packet_word_i = $urandom;
            end
            cyc();
        end
        chk("random_no_perr", 32'(perr), 32'd0);

        // STALL: valid dropped while stalled sets a sticky error
        mode = 2'd3;
        do_reset();
        bus.packet_word_valid_i = 1'b1;
        bus.packet_word_i = 32'd5;
        repeat (2) cyc();
        bus.packet_word_valid_i = 1'b0;
        cyc();
        chk("perr_set", 32'(perr), 32'd1);
        repeat (4) cyc();
        chk("perr_sticky", 32'(perr), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_perr", 32'(perr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-transfer discards the word in flight
        mode = 2'd0;
        do_reset();
        bus.packet_word_valid_i = 1'b1;
        bus.packet_word_i = 32'hA0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (last_xfer) bus.packet_word_i = bus.packet_word_i + 32'd1;
        end
        chk("pre_reset_grant", 32'(bus.grant_o), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Word counter wraps from all-ones to zero
        do_reset();
        repeat (2) cyc();
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.word_cnt_q;
        mwc = 32'hFFFF_FFFF;
        bus.packet_word_valid_i = 1'b1;
        bus.packet_word_i = 32'h77;
        cyc();
        chk("wc_wrap", wc, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
